// File: rtl/ram_port_arbiter.sv
// ---------------------------------------------------------------------------
// ram_port_arbiter
//
// Purpose:
//   Shares one single-port synchronous RAM between two masters. Arbitration
//   is combinational (zero-cycle grant) with a one-bit rotating priority, so
//   under continuous contention the grants alternate. Every granted
//   transaction, whether read or write, returns exactly one rvalid pulse to
//   its owner one cycle later. Read data is passed straight from the RAM.
//
// Ports:
//   clk                      clock, rising edge
//   rst_i                    synchronous active-high reset
//   m0_*_i / m1_*_i          master request: req, addr, we, be, wdata
//   m0_gnt_o / m1_gnt_o      request accepted this cycle (combinational)
//   m0_rvalid_o/m1_rvalid_o  one-cycle response pulse, one cycle after grant
//   m0_rdata_o / m1_rdata_o  read data (zero unless a read response)
//   ram_en_o, ram_we_o       RAM enable / write enable
//   ram_addr_o, ram_be_o,
//   ram_wdata_o              RAM request fields from the granted master
//   ram_rdata_i              RAM read data, valid one cycle after a read
// ---------------------------------------------------------------------------
module ram_port_arbiter #(
   parameter int ADDR_WIDTH = 15,
   parameter int DATA_WIDTH = 32
) (
   input  logic                      clk,
   input  logic                      rst_i,

   input  logic                      m0_req_i,
   input  logic [ADDR_WIDTH-1:0]     m0_addr_i,
   input  logic                      m0_we_i,
   input  logic [DATA_WIDTH/8-1:0]   m0_be_i,
   input  logic [DATA_WIDTH-1:0]     m0_wdata_i,
   output logic                      m0_gnt_o,
   output logic                      m0_rvalid_o,
   output logic [DATA_WIDTH-1:0]     m0_rdata_o,

   input  logic                      m1_req_i,
   input  logic [ADDR_WIDTH-1:0]     m1_addr_i,
   input  logic                      m1_we_i,
   input  logic [DATA_WIDTH/8-1:0]   m1_be_i,
   input  logic [DATA_WIDTH-1:0]     m1_wdata_i,
   output logic                      m1_gnt_o,
   output logic                      m1_rvalid_o,
   output logic [DATA_WIDTH-1:0]     m1_rdata_o,

   output logic                      ram_en_o,
   output logic                      ram_we_o,
   output logic [ADDR_WIDTH-1:0]     ram_addr_o,
   output logic [DATA_WIDTH/8-1:0]   ram_be_o,
   output logic [DATA_WIDTH-1:0]     ram_wdata_o,
   input  logic [DATA_WIDTH-1:0]     ram_rdata_i
);

   localparam int BE_WIDTH = DATA_WIDTH / 8;

   // Arbitration state: index of the master favoured on contention.
   logic r_prio_q;

   // Response state for the transaction granted in the previous cycle.
   logic r_rsp_valid_q;
   logic r_rsp_owner_q;
   logic r_rsp_read_q;

   logic w_gnt0;
   logic w_gnt1;
   logic w_any_gnt;
   logic w_gnt_idx;
   logic w_gnt_we;
   logic w_rsp_live;

   // ------------------------------------------------------------------------
   // Stage 0: combinational grant and RAM request mux
   // ------------------------------------------------------------------------
   always_comb begin
      w_gnt0    = m0_req_i & (~m1_req_i | ~r_prio_q);
      w_gnt1    = m1_req_i & (~m0_req_i |  r_prio_q);
      w_any_gnt = w_gnt0 | w_gnt1;
      w_gnt_idx = w_gnt1;
   end

   always_comb begin
      ram_en_o    = 1'b0;
      ram_we_o    = 1'b0;
      ram_addr_o  = '0;
      ram_be_o    = '0;
      ram_wdata_o = '0;
      if (w_gnt0) begin
         ram_en_o    = 1'b1;
         ram_we_o    = m0_we_i;
         ram_addr_o  = m0_addr_i;
         ram_be_o    = m0_be_i;
         ram_wdata_o = m0_wdata_i;
      end else if (w_gnt1) begin
         ram_en_o    = 1'b1;
         ram_we_o    = m1_we_i;
         ram_addr_o  = m1_addr_i;
         ram_be_o    = m1_be_i;
         ram_wdata_o = m1_wdata_i;
      end
   end

   assign w_gnt_we = ram_we_o;
   assign m0_gnt_o = w_gnt0;
   assign m1_gnt_o = w_gnt1;

   // ------------------------------------------------------------------------
   // Stage 0 -> 1: priority rotation and response capture
   // ------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst_i) begin
         r_prio_q      <= 1'b0;
         r_rsp_valid_q <= 1'b0;
         r_rsp_owner_q <= 1'b0;
         r_rsp_read_q  <= 1'b0;
      end else begin
         // rsp_valid is a single-cycle pulse; it drops whenever no grant.
         r_rsp_valid_q <= w_any_gnt;
         if (w_any_gnt) begin
            // Favour the loser next time: strict alternation under contention.
            r_prio_q      <= ~w_gnt_idx;
            r_rsp_owner_q <= w_gnt_idx;
            r_rsp_read_q  <= ~w_gnt_we;
         end
      end
   end

   // ------------------------------------------------------------------------
   // Stage 1: response routing
   // ------------------------------------------------------------------------
   // Masking with rst_i drops a response that is in flight when reset hits.
   assign w_rsp_live  = r_rsp_valid_q & ~rst_i;
   assign m0_rvalid_o = w_rsp_live & ~r_rsp_owner_q;
   assign m1_rvalid_o = w_rsp_live &  r_rsp_owner_q;

   always_comb begin
      m0_rdata_o = '0;
      m1_rdata_o = '0;
      if (m0_rvalid_o && r_rsp_read_q) m0_rdata_o = ram_rdata_i;
      if (m1_rvalid_o && r_rsp_read_q) m1_rdata_o = ram_rdata_i;
   end

   // Byte-enable width is tied to the data width; keep it referenced.
   logic [BE_WIDTH-1:0] w_be_unused;
   assign w_be_unused = ram_be_o;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_ram_port_arbiter
//
// Directed scenarios followed by randomized traffic. A behavioural reference
// (last-winner rotation, one pending response, shadow word memory) predicts
// every output each cycle; a small RAM model drives ram_rdata_i.
// ---------------------------------------------------------------------------
module tb_ram_port_arbiter;

   localparam int AW = 15;
   localparam int DW = 32;
   localparam int BW = DW / 8;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          rst_i;
   logic          m0_req_i, m0_we_i, m1_req_i, m1_we_i;
   logic [AW-1:0] m0_addr_i, m1_addr_i;
   logic [BW-1:0] m0_be_i, m1_be_i;
   logic [DW-1:0] m0_wdata_i, m1_wdata_i;
   logic          m0_gnt_o, m1_gnt_o, m0_rvalid_o, m1_rvalid_o;
   logic [DW-1:0] m0_rdata_o, m1_rdata_o;
   logic          ram_en_o, ram_we_o;
   logic [AW-1:0] ram_addr_o;
   logic [BW-1:0] ram_be_o;
   logic [DW-1:0] ram_wdata_o;
   logic [DW-1:0] ram_rdata_i = '0;

   ram_port_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
      .clk(clk), .rst_i(rst_i),
      .m0_req_i(m0_req_i), .m0_addr_i(m0_addr_i), .m0_we_i(m0_we_i),
      .m0_be_i(m0_be_i), .m0_wdata_i(m0_wdata_i), .m0_gnt_o(m0_gnt_o),
      .m0_rvalid_o(m0_rvalid_o), .m0_rdata_o(m0_rdata_o),
      .m1_req_i(m1_req_i), .m1_addr_i(m1_addr_i), .m1_we_i(m1_we_i),
      .m1_be_i(m1_be_i), .m1_wdata_i(m1_wdata_i), .m1_gnt_o(m1_gnt_o),
      .m1_rvalid_o(m1_rvalid_o), .m1_rdata_o(m1_rdata_o),
      .ram_en_o(ram_en_o), .ram_we_o(ram_we_o), .ram_addr_o(ram_addr_o),
      .ram_be_o(ram_be_o), .ram_wdata_o(ram_wdata_o), .ram_rdata_i(ram_rdata_i)
   );

   // RAM model: 16 words, indexed by word address bits [5:2]. Outside read
   // cycles the read bus carries garbage so unguarded rdata paths show up.
   logic [DW-1:0] ram_mem [16];
   initial for (int i = 0; i < 16; i++) ram_mem[i] = '0;

   always @(posedge clk) begin
      if (ram_en_o && ram_we_o) begin
         for (int b = 0; b < BW; b++)
            if (ram_be_o[b]) ram_mem[ram_addr_o[5:2]][8*b +: 8] <= ram_wdata_o[8*b +: 8];
         ram_rdata_i <= $urandom;
      end else if (ram_en_o) begin
         ram_rdata_i <= ram_mem[ram_addr_o[5:2]];
      end else begin
         ram_rdata_i <= $urandom;
      end
   end

   // Stimulus staging
   logic          s_rst, s_req0, s_we0, s_req1, s_we1;
   logic [AW-1:0] s_addr0, s_addr1;
   logic [BW-1:0] s_be0, s_be1;
   logic [DW-1:0] s_wd0, s_wd1;

   // Reference model state
   int            m_last;     // master that won most recently (1 => m0 favoured)
   bit            m_pv;       // a response is due next cycle
   int            m_pown;
   bit            m_prd;
   logic [DW-1:0] m_pdata;
   logic [DW-1:0] sh_mem [16];

   // Snapshot of DUT outputs for the latest cycle
   logic          o_gnt0, o_gnt1, o_en, o_we, o_rv0, o_rv1;
   logic [AW-1:0] o_addr;
   logic [BW-1:0] o_be;
   logic [DW-1:0] o_wd, o_rd0, o_rd1;

   int n_checks = 0;
   int n_errors = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   task automatic idle();
      s_rst = 1'b0; s_req0 = 1'b0; s_req1 = 1'b0;
   endtask

   task automatic set0(input logic we, input logic [AW-1:0] a, input logic [BW-1:0] be,
                       input logic [DW-1:0] d);
      s_req0 = 1'b1; s_we0 = we; s_addr0 = a; s_be0 = be; s_wd0 = d;
   endtask

   task automatic set1(input logic we, input logic [AW-1:0] a, input logic [BW-1:0] be,
                       input logic [DW-1:0] d);
      s_req1 = 1'b1; s_we1 = we; s_addr1 = a; s_be1 = be; s_wd1 = d;
   endtask

   // One clock: apply staged inputs at the falling edge, check all outputs
   // against the reference, advance the reference, wait for the rising edge.
   task automatic do_cycle();
      int            win;
      logic          e_we;
      logic [AW-1:0] e_addr;
      logic [BW-1:0] e_be;
      logic [DW-1:0] e_wd;
      logic          e_rv0, e_rv1;
      logic [DW-1:0] e_rd0, e_rd1;
      logic [3:0]    idx;
      @(negedge clk);
      rst_i = s_rst;
      m0_req_i = s_req0; m0_we_i = s_we0; m0_addr_i = s_addr0; m0_be_i = s_be0; m0_wdata_i = s_wd0;
      m1_req_i = s_req1; m1_we_i = s_we1; m1_addr_i = s_addr1; m1_be_i = s_be1; m1_wdata_i = s_wd1;
      #1;
      o_gnt0 = m0_gnt_o; o_gnt1 = m1_gnt_o; o_en = ram_en_o; o_we = ram_we_o;
      o_addr = ram_addr_o; o_be = ram_be_o; o_wd = ram_wdata_o;
      o_rv0 = m0_rvalid_o; o_rv1 = m1_rvalid_o; o_rd0 = m0_rdata_o; o_rd1 = m1_rdata_o;

      if (s_req0 && s_req1) win = (m_last == 0) ? 1 : 0;
      else if (s_req0)      win = 0;
      else if (s_req1)      win = 1;
      else                  win = -1;

      e_we = 1'b0; e_addr = '0; e_be = '0; e_wd = '0;
      if (win == 0) begin e_we = s_we0; e_addr = s_addr0; e_be = s_be0; e_wd = s_wd0; end
      if (win == 1) begin e_we = s_we1; e_addr = s_addr1; e_be = s_be1; e_wd = s_wd1; end

      e_rv0 = m_pv && !s_rst && m_pown == 0;
      e_rv1 = m_pv && !s_rst && m_pown == 1;
      e_rd0 = (e_rv0 && m_prd) ? m_pdata : '0;
      e_rd1 = (e_rv1 && m_prd) ? m_pdata : '0;

      chk("gnt0", o_gnt0, win == 0);
      chk("gnt1", o_gnt1, win == 1);
      chk("ram_en", o_en, win >= 0);
      chk("ram_we", o_we, e_we);
      chk("ram_addr", o_addr, e_addr);
      chk("ram_be", o_be, e_be);
      chk("ram_wdata", o_wd, e_wd);
      chk("rvalid0", o_rv0, e_rv0);
      chk("rvalid1", o_rv1, e_rv1);
      chk("rdata0", o_rd0, e_rd0);
      chk("rdata1", o_rd1, e_rd1);

      idx = e_addr[5:2];
      if (win >= 0) begin
         m_pdata = sh_mem[idx];
         if (e_we)
            for (int b = 0; b < BW; b++)
               if (e_be[b]) sh_mem[idx][8*b +: 8] = e_wd[8*b +: 8];
      end
      if (s_rst) begin
         m_last = 1; m_pv = 1'b0;
      end else if (win >= 0) begin
         m_last = win; m_pv = 1'b1; m_pown = win; m_prd = !e_we;
      end else begin
         m_pv = 1'b0;
      end
      @(posedge clk);
   endtask

   initial begin
      for (int i = 0; i < 16; i++) sh_mem[i] = '0;
      m_last = 1; m_pv = 1'b0; m_pown = 0; m_prd = 1'b0; m_pdata = '0;
      s_we0 = 0; s_addr0 = '0; s_be0 = '0; s_wd0 = '0;
      s_we1 = 0; s_addr1 = '0; s_be1 = '0; s_wd1 = '0;
      idle();

      // Reset: nothing valid
      s_rst = 1'b1; do_cycle(); do_cycle(); idle();
      chk("rst_rv0", o_rv0, 1'b0);
      chk("rst_rd0", o_rd0, '0);

      // Preload 0x0010, reset, then a single read of it
      set0(1'b1, 15'h0010, 4'hF, 32'hDEADBEEF); do_cycle(); idle();
      s_rst = 1'b1; do_cycle(); idle();
      set0(1'b0, 15'h0010, 4'hF, 32'h0); do_cycle(); idle();
      chk("r31_gnt0", o_gnt0, 1'b1);
      chk("r31_en", o_en, 1'b1);
      chk("r31_addr", o_addr, 15'h0010);
      do_cycle();
      chk("r31_rv0", o_rv0, 1'b1);
      chk("r31_rd0", o_rd0, 32'hDEADBEEF);

      // Contention for 4 cycles after reset: m0, m1, m0, m1
      s_rst = 1'b1; do_cycle(); idle();
      for (int i = 0; i < 4; i++) begin
         set0(1'b0, AW'(4 * i), 4'hF, '0);
         set1(1'b0, AW'(4 * i + 32), 4'hF, '0);
         do_cycle();
         chk("r32_gnt0", o_gnt0, (i % 2) == 0);
         chk("r32_gnt1", o_gnt1, (i % 2) == 1);
         if (i > 0) chk("r32_rv1", o_rv1, (i % 2) == 0);
      end
      idle(); do_cycle();
      chk("r32_last_rv1", o_rv1, 1'b1);

      // m1 partial write
      set1(1'b1, 15'h0100, 4'b0011, 32'hCAFEF00D); do_cycle(); idle();
      chk("r33_we", o_we, 1'b1);
      chk("r33_be", o_be, 4'b0011);
      chk("r33_wd", o_wd, 32'hCAFEF00D);
      do_cycle();
      chk("r33_rv1", o_rv1, 1'b1);
      chk("r33_rd1", o_rd1, '0);

      // m0 alone, three back-to-back reads; then contention must favour m1
      for (int i = 0; i < 3; i++) begin
         set0(1'b0, AW'(4 * i), 4'hF, '0); do_cycle();
         chk("r34_gnt0", o_gnt0, 1'b1);
         if (i > 0) chk("r34_rv0", o_rv0, 1'b1);
      end
      idle(); do_cycle();
      chk("r34_rv0_last", o_rv0, 1'b1);
      set0(1'b0, '0, '0, '0); set1(1'b0, '0, '0, '0); do_cycle(); idle();
      chk("r34_prio1", o_gnt1, 1'b1);

      // Reset right after an m1 read grant drops the response
      set1(1'b0, 15'h0100, 4'hF, '0); do_cycle(); idle();
      s_rst = 1'b1; do_cycle(); idle();
      chk("r35_rv1_rst", o_rv1, 1'b0);
      do_cycle();
      chk("r35_rv1_after", o_rv1, 1'b0);
      set0(1'b0, '0, '0, '0); set1(1'b0, '0, '0, '0); do_cycle(); idle();
      chk("r35_prio0", o_gnt0, 1'b1);

      // Ten idle cycles keep the bus quiet and the priority held (m1 next)
      for (int i = 0; i < 10; i++) do_cycle();
      set0(1'b0, '0, '0, '0); set1(1'b0, '0, '0, '0); do_cycle(); idle();
      chk("r36_prio_hold", o_gnt1, 1'b1);

      // Randomized traffic
      for (int i = 0; i < 600; i++) begin
         s_rst  = ($urandom_range(0, 39) == 0);
         s_req0 = ($urandom_range(0, 2) != 0);
         s_req1 = ($urandom_range(0, 2) != 0);
         s_we0  = 1'($urandom_range(0, 1));
         s_we1  = 1'($urandom_range(0, 1));
         s_addr0 = AW'($urandom); s_addr1 = AW'($urandom);
         s_be0 = BW'($urandom);   s_be1 = BW'($urandom);
         s_wd0 = $urandom;        s_wd1 = $urandom;
         do_cycle();
      end
      idle(); do_cycle(); do_cycle();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
